// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the float add and subtract units:
// field widths, special encodings, FSM states and operand classification.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;
  localparam int SIG_W = MAN_W + 1;

  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    fp_class_t        cls;
  } unpacked_t;

  // Subnormals are flushed here, so downstream logic only ever sees
  // zero, normal, inf or NaN operands.
  function automatic unpacked_t unpack(input logic [15:0] value);
    unpacked_t u;
    u.sign = value[15];
    u.exp  = value[14:10];
    u.sig  = {1'b1, value[9:0]};
    u.cls  = NORMAL;
    if (value[14:10] == '0) begin
      u.exp = '0;
      u.sig = '0;
      u.cls = ZERO;
    end else if (value[14:10] == EXP_MAX) begin
      u.cls = (value[9:0] != '0) ? NAN : INF;
    end
    return u;
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Combinational 12-bit leading-zero counter; an all-zero input yields 12.
module fp16_lzc (
  input  logic [11:0] value,
  output logic [3:0]  count
);

  logic found;

  always_comb begin
    count = 4'd12;
    found = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = 4'(11 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/float_add.sv
// Multi-cycle binary16 adder with a call/done handshake; fixed five-cycle
// latency from the accepted call to the done pulse, truncating rounding.
module float_add
  import fp16_pkg::*;
(
  input  logic        clock,
  input  logic        nreset,
  input  logic        call_fAdd,
  input  logic [15:0] left,
  input  logic [15:0] right,
  output logic [15:0] data_out,
  output logic        add_done,
  output logic        add_busy
);

  state_t state;
  state_t next_state;

  logic [15:0] op_a;
  logic [15:0] op_b;
  unpacked_t   ua;
  unpacked_t   ub;

  logic             hi_sign;
  logic [EXP_W-1:0] hi_exp;
  logic [SIG_W-1:0] hi_sig;
  logic             lo_sign;
  logic [SIG_W-1:0] lo_sig;
  logic             zero_sign;
  logic             special_hit;
  logic [15:0]      special_val;
  logic [11:0]      sum_r;

  always_ff @(posedge clock) begin
    if (!nreset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    add_busy   = 1'b0;
    add_done   = 1'b0;
    case (state)
      IDLE:    next_state = call_fAdd ? UNPACK : IDLE;
      UNPACK:  begin next_state = ALIGN; add_busy = 1'b1; end
      ALIGN:   begin next_state = ADD;   add_busy = 1'b1; end
      ADD:     begin next_state = NORM;  add_busy = 1'b1; end
      NORM:    begin next_state = DONE;  add_busy = 1'b1; end
      DONE:    begin next_state = IDLE;  add_busy = 1'b1; add_done = 1'b1; end
      default: next_state = IDLE;
    endcase
  end

  // Alignment: the larger magnitude becomes the reference operand.
  logic             a_bigger;
  unpacked_t        hi;
  unpacked_t        lo;
  logic [EXP_W-1:0] exp_diff;
  logic [SIG_W-1:0] lo_shifted;
  logic             spec_hit_c;
  logic [15:0]      spec_val_c;

  always_comb begin
    a_bigger   = {ua.exp, ua.sig[MAN_W-1:0]} >= {ub.exp, ub.sig[MAN_W-1:0]};
    hi         = a_bigger ? ua : ub;
    lo         = a_bigger ? ub : ua;
    exp_diff   = hi.exp - lo.exp;
    lo_shifted = (exp_diff >= 5'd12) ? '0 : (lo.sig >> exp_diff);

    spec_hit_c = 1'b1;
    spec_val_c = QNAN;
    if (ua.cls == NAN || ub.cls == NAN) begin
      spec_val_c = QNAN;
    end else if (ua.cls == INF && ub.cls == INF && ua.sign != ub.sign) begin
      spec_val_c = QNAN;
    end else if (ua.cls == INF) begin
      spec_val_c = ua.sign ? NEG_INF : POS_INF;
    end else if (ub.cls == INF) begin
      spec_val_c = ub.sign ? NEG_INF : POS_INF;
    end else begin
      spec_hit_c = 1'b0;
    end
  end

  // Ordering guarantees the difference path never underflows.
  logic [11:0] sum_c;

  always_comb begin
    if (hi_sign == lo_sign) sum_c = {1'b0, hi_sig} + {1'b0, lo_sig};
    else                    sum_c = {1'b0, hi_sig} - {1'b0, lo_sig};
  end

  logic [3:0]  lz_count;
  logic [3:0]  shift_amt;
  logic [11:0] sum_shifted;
  logic [6:0]  norm_exp;
  logic [9:0]  norm_sig;
  logic [15:0] result_c;

  fp16_lzc u_lzc (
    .value (sum_r),
    .count (lz_count)
  );

  // Exponent is kept two bits wider so underflow shows up in bit 6.
  always_comb begin
    shift_amt   = lz_count - 4'd1;
    sum_shifted = sum_r << shift_amt;
    if (sum_r[11]) begin
      norm_exp = {2'b00, hi_exp} + 7'd1;
      norm_sig = sum_r[10:1];
    end else begin
      norm_exp = {2'b00, hi_exp} - {3'b000, shift_amt};
      norm_sig = sum_shifted[9:0];
    end

    if (special_hit)
      result_c = special_val;
    else if (sum_r == '0)
      result_c = {zero_sign, 15'h0000};
    else if (!norm_exp[6] && norm_exp >= 7'd31)
      result_c = hi_sign ? NEG_INF : POS_INF;
    else if (norm_exp[6] || norm_exp == '0)
      result_c = {hi_sign, 15'h0000};
    else
      result_c = {hi_sign, norm_exp[4:0], norm_sig};
  end

  // One datapath stage per state; data_out is loaded as the FSM enters DONE.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      op_a        <= '0;
      op_b        <= '0;
      ua          <= '0;
      ub          <= '0;
      hi_sign     <= 1'b0;
      hi_exp      <= '0;
      hi_sig      <= '0;
      lo_sign     <= 1'b0;
      lo_sig      <= '0;
      zero_sign   <= 1'b0;
      special_hit <= 1'b0;
      special_val <= '0;
      sum_r       <= '0;
      data_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (call_fAdd) begin
            op_a <= left;
            op_b <= right;
          end
        end
        UNPACK: begin
          ua <= unpack(op_a);
          ub <= unpack(op_b);
        end
        ALIGN: begin
          hi_sign     <= hi.sign;
          hi_exp      <= hi.exp;
          hi_sig      <= hi.sig;
          lo_sign     <= lo.sign;
          lo_sig      <= lo_shifted;
          zero_sign   <= ua.sign & ub.sign;
          special_hit <= spec_hit_c;
          special_val <= spec_val_c;
        end
        ADD: begin
          sum_r <= sum_c;
        end
        NORM: begin
          data_out <= result_c;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_add.sv
// Randomised scoreboard bench for float_add against an integer-arithmetic
// model of binary16 addition with flush-to-zero and truncation.
module tb_float_add;

  logic        clock = 1'b0;
  logic        nreset;
  logic        call_fAdd;
  logic [15:0] left;
  logic [15:0] right;
  logic [15:0] data_out;
  logic        add_done;
  logic        add_busy;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] want;
    int          cycle;
  } txn_t;

  txn_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  float_add dut (
    .clock     (clock),
    .nreset    (nreset),
    .call_fAdd (call_fAdd),
    .left      (left),
    .right     (right),
    .data_out  (data_out),
    .add_done  (add_done),
    .add_busy  (add_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int  ea, eb, ma, mb, siga, sigb, s, e, d, tmp;
    bit  sa, sb, sgn;
    sa = a[15]; ea = int'(a[14:10]); ma = int'(a[9:0]);
    sb = b[15]; eb = int'(b[14:10]); mb = int'(b[9:0]);
    if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0)) return 16'h7E00;
    if (ea == 31 && eb == 31 && sa != sb) return 16'h7E00;
    if (ea == 31) return a;
    if (eb == 31) return b;
    if (ea == 0) ma = 0;
    if (eb == 0) mb = 0;
    if (eb * 1024 + mb > ea * 1024 + ma) begin
      tmp = ea; ea = eb; eb = tmp;
      tmp = ma; ma = mb; mb = tmp;
      sgn = sa; sa = sb; sb = sgn;
    end
    siga = (ea != 0) ? 1024 + ma : 0;
    sigb = (eb != 0) ? 1024 + mb : 0;
    d = ea - eb;
    sigb = (d >= 12) ? 0 : sigb / (1 << d);
    s = (sa == sb) ? siga + sigb : siga - sigb;
    if (s == 0) return {sa & sb, 15'h0000};
    e = ea;
    while (s >= 2048) begin s = s / 2; e = e + 1; end
    while (s < 1024) begin s = s * 2; e = e - 1; end
    if (e >= 31) return {sa, 15'h7C00};
    if (e <= 0) return {sa, 15'h0000};
    return {sa, 5'(e), 10'(s - 1024)};
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 9))
      0: v[14:10] = 5'd31;
      1: v[14:10] = 5'd0;
      2: v[14:10] = 5'(28 + $urandom_range(0, 2));
      default: v[14:10] = 5'(10 + $urandom_range(0, 10));
    endcase
    return v;
  endfunction

  task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b);
    txn_t t;
    int   busy_n;
    int   guard;
    @(negedge clock);
    left      = a;
    right     = b;
    call_fAdd = 1'b1;
    t.a = a; t.b = b; t.want = ref_add(a, b); t.cycle = cycle;
    sb_q.push_back(t);
    @(negedge clock);
    call_fAdd = 1'b0;
    busy_n = 0;
    guard  = 0;
    while (add_busy === 1'b1 && guard < 20) begin
      busy_n++;
      guard++;
      @(negedge clock);
    end
    check_output($sformatf("busy_cycles %h+%h", a, b), 16'(busy_n), 16'd5);
  endtask

  initial begin
    txn_t t;
    logic [15:0] a, b;
    logic [15:0] directed [11][2] = '{
      '{16'h3C00, 16'h4000}, '{16'h3C00, 16'hBC00}, '{16'h3E00, 16'h3800},
      '{16'h7BFF, 16'h7BFF}, '{16'h7C00, 16'hFC00}, '{16'h7E01, 16'h3C00},
      '{16'hFC00, 16'h4000}, '{16'h0001, 16'h3C00}, '{16'h8000, 16'h8000},
      '{16'h8000, 16'h0000}, '{16'h0400, 16'h8401}
    };

    nreset    = 1'b0;
    call_fAdd = 1'b0;
    left      = '0;
    right     = '0;

    fork
      forever begin
        @(negedge clock);
        if (add_done === 1'b1) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done got data_out=%h want no done", data_out);
          end else begin
            t = sb_q.pop_front();
            check_output($sformatf("result %h+%h", t.a, t.b), data_out, t.want);
            check_output("latency", 16'(cycle - t.cycle), 16'd5);
          end
        end
      end
    join_none

    repeat (3) @(negedge clock);
    check_output("reset_data_out", data_out, 16'h0000);
    check_output("reset_busy", {15'd0, add_busy}, 16'd0);
    check_output("reset_done", {15'd0, add_done}, 16'd0);
    nreset = 1'b1;

    foreach (directed[i]) apply_stimulus(directed[i][0], directed[i][1]);

    for (int i = 0; i < 400; i++) begin
      a = rand_fp();
      case ($urandom_range(0, 3))
        0: b = a ^ 16'h8000;
        1: begin b = rand_fp(); b[14:10] = a[14:10] - 5'($urandom_range(0, 13)); end
        default: b = rand_fp();
      endcase
      apply_stimulus(a, b);
    end

    // Calls raised during ALIGN and DONE must be ignored.
    @(negedge clock);
    left = 16'h3C00; right = 16'h4000; call_fAdd = 1'b1;
    t.a = 16'h3C00; t.b = 16'h4000; t.want = 16'h4200; t.cycle = cycle;
    sb_q.push_back(t);
    @(negedge clock); call_fAdd = 1'b0;
    @(negedge clock); call_fAdd = 1'b1; left = 16'h4400; right = 16'h4400;
    @(negedge clock); call_fAdd = 1'b0;
    @(negedge clock);
    @(negedge clock); call_fAdd = 1'b1;
    @(negedge clock); call_fAdd = 1'b0;
    check_output("busy_after_ignored_call", {15'd0, add_busy}, 16'd0);
    repeat (8) @(negedge clock);
    check_output("held_data_out", data_out, 16'h4200);

    // Reset in the middle of an operation aborts it silently.
    left = 16'h4000; right = 16'h4000; call_fAdd = 1'b1;
    @(negedge clock); call_fAdd = 1'b0;
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b0;
    @(negedge clock);
    nreset = 1'b1;
    check_output("abort_data_out", data_out, 16'h0000);
    check_output("abort_busy", {15'd0, add_busy}, 16'd0);
    check_output("abort_done", {15'd0, add_done}, 16'd0);
    repeat (8) @(negedge clock);
    apply_stimulus(16'h3E00, 16'h3800);

    repeat (4) @(negedge clock);
    check_output("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
